grf_write_arbiter: RTL and testbench
====================================

# grf_write_arbiter

Shares the single write port of the general register file between the pipeline writeback stage and the long-latency multiply/divide unit. Writeback always has priority and is never delayed. Multiply/divide results are buffered in a small in-order FIFO and drained on cycles where writeback does not write. The block also exports a per-register busy vector and a starvation flag, which the hazard unit uses to stall decode-stage reads and to insert bubbles.

## Interface
Parameters:
- DEPTH, 2: FIFO entries for multiply/divide results (power of two, ≥2).
- STARVE_MAX, 4: head-of-FIFO wait cycles before MdStarve asserts.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- WbWe  in  1  writeback write request.
- WbA3  in  5  writeback destination register.
- WbWd  in  32  writeback data.
- MdValid  in  1  multiply/divide result valid.
- MdA3  in  5  multiply/divide destination register.
- MdWd  in  32  multiply/divide data.
- MdReady  out  1  FIFO can accept a result this cycle.
- We  out  1  register-file write enable.
- A3  out  5  register-file write address.
- Wd  out  32  register-file write data.
- Busy  out  32  bit r = a valid FIFO entry targets register r; bit 0 is always 0.
- MdStarve  out  1  FIFO head has waited ≥ STARVE_MAX cycles.

## Operation
- WB request is active when WbWe=1 and WbA3≠0. A writeback to register 0 is ignored entirely.
- Grant rule, evaluated every cycle:
  - If the WB request is active, drive We=1, A3=WbA3, Wd=WbWd.
  - Otherwise, if the FIFO is non-empty, drive the head entry and pop it at the clock edge.
  - Otherwise drive We=0, A3=0, Wd=0.
- The output mux is combinational. The WB path adds no latency.
- MdReady = !full && !Reset. A push happens when MdValid && MdReady at the edge.
  - If MdA3=0, the handshake completes but nothing is enqueued.
  - A pop and a push in the same cycle are legal when the FIFO is non-full.
  - A full FIFO never accepts, even if it pops that cycle.
- WAW squash: when an active WB write targets r, every valid FIFO entry with A3=r is invalidated at that edge. Invalidated entries are skipped, never written, and free their slots.
  - An entry pushed in the same cycle with MdA3=r is not squashed. It is younger than the WB write and is kept.
- Busy is the OR over valid FIFO entries of the decoded A3, taken from registered state only.
- Age counter:
  - Clears on any pop, when the FIFO is empty, and on reset.
  - Otherwise increments each cycle the head waits, saturating at STARVE_MAX.
  - MdStarve = (age == STARVE_MAX).
- FIFO pointers wrap modulo DEPTH. An occupancy counter of width clog2(DEPTH)+1 distinguishes full from empty.

## Timing
- Reset values: FIFO empty, all entries invalid, age 0. Outputs: We=0, A3=0, Wd=0, Busy=0, MdStarve=0, MdReady=0 during Reset, then 1.
- Reset mid-operation discards all buffered entries. No pending write reaches the register file.
- A result accepted at edge t:
  - sets Busy after t;
  - is written to the register file at edge t+1 at the earliest, and later if WB occupies those cycles;
  - has its Busy bit cleared by the same edge that writes it.
- If WB writes every cycle, the head waits and MdStarve rises after STARVE_MAX waiting cycles. The hazard unit must then supply a WB-free cycle; MdStarve falls after the pop.
- The head is recomputed after a squash. A squash of the head and a pop cannot coincide, because a pop only happens when WB is idle.

## Structure
- A shared package holds:
  - REG_ZERO = 5'd0;
  - the typedef md_entry_t {valid, a3[4:0], wd[31:0]};
  - the DEPTH and STARVE_MAX defaults.
- One sub-module, grf_md_fifo: storage, pointers, occupancy, per-entry squash and skip-invalid head logic.
- The arbiter top contains the grant mux, age counter and Busy reduction.

## Test plan
- Reset held 2 cycles → We=0, Busy=0, MdReady=0; the cycle after release MdReady=1.
- MdValid with MdA3=5, MdWd=0x1234 at edge t, WB idle → Busy[5]=1 after t; We=1, A3=5, Wd=0x1234 in cycle t+1; Busy[5]=0 after t+1.
- WB writes reg 7 for 6 consecutive cycles while the FIFO holds an entry for reg 9 → WB wins every cycle; MdStarve=1 after 4 waiting cycles; the entry for reg 9 is written in the first WB-idle cycle, then MdStarve=0.
- Push entries for 3 and 4 (FIFO full, DEPTH=2) → MdReady=0; a third MdValid is held off until a pop, and entries drain in order 3, 4.
- FIFO holds an entry for reg 8, then WB writes reg 8 with 0xAAAA → the entry is squashed, Busy[8]=0, and register 8 is never overwritten by the Md data.
- MdA3=0 accepted, or WbA3=0 with WbWe=1 → no write reaches the register file and Busy stays 0.

Source files
------------

// File: rtl/grf_write_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package grf_write_arbiter_pkg;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         DEPTH_DEF      = 2;
  localparam int         STARVE_MAX_DEF = 4;

  // One buffered multiply/divide result.
  typedef struct packed {
    logic        valid;
    logic [4:0]  a3;
    logic [31:0] wd;
  } md_entry_t;

endpackage

// File: rtl/grf_write_arbiter_if.sv
// Writeback, multiply/divide and register-file write-port signals of the arbiter.
interface grf_write_arbiter_if;

  logic        WbWe;
  logic [4:0]  WbA3;
  logic [31:0] WbWd;
  logic        MdValid;
  logic [4:0]  MdA3;
  logic [31:0] MdWd;
  logic        MdReady;
  logic        We;
  logic [4:0]  A3;
  logic [31:0] Wd;
  logic [31:0] Busy;
  logic        MdStarve;

  // Pipeline / hazard-unit side.
  modport master (
    output WbWe, WbA3, WbWd, MdValid, MdA3, MdWd,
    input  MdReady, We, A3, Wd, Busy, MdStarve
  );

  // Arbiter side.
  modport slave (
    input  WbWe, WbA3, WbWd, MdValid, MdA3, MdWd,
    output MdReady, We, A3, Wd, Busy, MdStarve
  );

endinterface

// File: rtl/grf_md_fifo.sv
// In-order buffer for multiply/divide results with per-entry WAW squash.
// Squashed entries at either end of the occupied span are retired at the
// same edge, so the registered head slot is always a valid entry.
module grf_md_fifo
  import grf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  push_i,
  input  logic [4:0]            push_a3_i,
  input  logic [31:0]           push_wd_i,
  input  logic                  pop_i,
  input  logic                  squash_i,
  input  logic [4:0]            squash_a3_i,
  output logic                  full_o,
  output logic                  empty_o,
  output md_entry_t             head_o,
  output md_entry_t [DEPTH-1:0] entries_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  md_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] base_wr;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] live;
  logic [PTR_W-1:0] slot_idx [DEPTH];
  logic [DEPTH-1:0] occupied;
  logic [DEPTH-1:0] keep;
  logic [PTR_W-1:0] first_k, last_k;

  // Per age-ordered slot: is it occupied, and does it survive this edge's squash/pop.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      slot_idx[k] = rd_ptr_q + PTR_W'(k);
      occupied[k] = CNT_W'(k) < count_q;
      keep[k]     = occupied[k] && mem_q[slot_idx[k]].valid
                 && !(squash_i && (mem_q[slot_idx[k]].a3 == squash_a3_i))
                 && !(pop_i && (k == 0));
    end
  end

  // Trim dead slots off both ends of the span, then append the push.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves a latch.
    first_k  = '0;
    last_k   = '0;
    rd_ptr_d = wr_ptr_q;
    base_wr  = wr_ptr_q;
    live     = '0;
    for (int k = DEPTH - 1; k >= 0; k--) if (keep[k]) first_k = PTR_W'(k);
    for (int k = 0; k < DEPTH; k++)      if (keep[k]) last_k  = PTR_W'(k);
    if (|keep) begin
      rd_ptr_d = rd_ptr_q + first_k;
      base_wr  = rd_ptr_q + last_k + PTR_W'(1);
      live     = {1'b0, last_k} - {1'b0, first_k} + CNT_W'(1);
    end
    wr_ptr_d = base_wr + PTR_W'(push_i);
    count_d  = live + CNT_W'(push_i);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: invalidate dead slots, write the pushed result.
  // NOTE: storage is not reset; count_q qualifies every read, so stale slots are never seen.
  always_ff @(posedge Clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (occupied[k] && !keep[k]) mem_q[slot_idx[k]].valid <= 1'b0;
    end
    if (push_i) mem_q[base_wr] <= '{valid: 1'b1, a3: push_a3_i, wd: push_wd_i};
  end

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // Expose the head and all occupied entries with validity masked by occupancy.
  always_comb begin
    head_o       = mem_q[rd_ptr_q];
    head_o.valid = mem_q[rd_ptr_q].valid && !empty_o;
    for (int k = 0; k < DEPTH; k++) begin
      entries_o[k]       = mem_q[slot_idx[k]];
      entries_o[k].valid = mem_q[slot_idx[k]].valid && occupied[k];
    end
  end

endmodule

// File: rtl/grf_write_arbiter.sv
// Register-file write-port arbiter: writeback first, buffered multiply/divide
// results drained on writeback-idle cycles; exports Busy and MdStarve.
module grf_write_arbiter
  import grf_write_arbiter_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                Clk,
  input  logic                Reset,
  grf_write_arbiter_if.slave  grf_if
);

  localparam int AGE_W = $clog2(STARVE_MAX + 1);

  logic                  wb_active;
  logic                  md_ready;
  logic                  md_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  md_entry_t             head;
  md_entry_t [DEPTH-1:0] entries;
  logic [AGE_W-1:0]      age_q;
  logic                  we;
  logic [4:0]            a3;
  logic [31:0]           wd;
  logic [31:0]           busy;

  assign wb_active = grf_if.WbWe && (grf_if.WbA3 != REG_ZERO) && !Reset;
  assign md_ready  = !fifo_full && !Reset;
  assign md_push   = grf_if.MdValid && md_ready && (grf_if.MdA3 != REG_ZERO);
  assign fifo_pop  = !wb_active && !fifo_empty && !Reset;

  grf_md_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk         (Clk),
    .Reset       (Reset),
    .push_i      (md_push),
    .push_a3_i   (grf_if.MdA3),
    .push_wd_i   (grf_if.MdWd),
    .pop_i       (fifo_pop),
    .squash_i    (wb_active),
    .squash_a3_i (grf_if.WbA3),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head),
    .entries_o   (entries)
  );

  // Grant mux: writeback wins, else the FIFO head, else idle.
  always_comb begin
    we = 1'b0;
    a3 = REG_ZERO;
    wd = '0;
    if (wb_active) begin
      we = 1'b1;
      a3 = grf_if.WbA3;
      wd = grf_if.WbWd;
    end else if (fifo_pop) begin
      we = 1'b1;
      a3 = head.a3;
      wd = head.wd;
    end
  end

  // Head age: cleared on pop or empty, else counts waiting cycles up to STARVE_MAX.
  always_ff @(posedge Clk) begin
    if (Reset || fifo_pop || fifo_empty) begin
      age_q <= '0;
    end else if (age_q != AGE_W'(STARVE_MAX)) begin
      age_q <= age_q + AGE_W'(1);
    end
  end

  // Busy: decoded destinations of all valid buffered entries.
  always_comb begin
    busy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (entries[k].valid) busy[entries[k].a3] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  assign grf_if.MdReady  = md_ready;
  assign grf_if.We       = we;
  assign grf_if.A3       = a3;
  assign grf_if.Wd       = wd;
  assign grf_if.Busy     = busy;
  assign grf_if.MdStarve = (age_q == AGE_W'(STARVE_MAX));

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Bench for grf_write_arbiter: directed vector table, then randomized traffic
// checked against a queue-based reference model.
module tb_grf_write_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;
  localparam int N_RAND     = 800;

  logic Clk;
  logic Reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  grf_write_arbiter_if bus ();

  grf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .grf_if (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_a3;
    logic [31:0] wb_wd;
    logic        md_v;
    logic [4:0]  md_a3;
    logic [31:0] md_wd;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic [31:0] e_busy;
    logic        e_starve;
  } vec_t;

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
  } ref_t;

  vec_t vecs[$];
  ref_t mq[$];
  int   m_age;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic wb_we, input logic [4:0] wb_a3,
                     input logic [31:0] wb_wd, input logic md_v, input logic [4:0] md_a3,
                     input logic [31:0] md_wd, input logic e_we, input logic [4:0] e_a3,
                     input logic [31:0] e_wd, input logic e_rdy, input logic [31:0] e_busy,
                     input logic e_starve);
    vec_t v;
    v = '{rst, wb_we, wb_a3, wb_wd, md_v, md_a3, md_wd, e_we, e_a3, e_wd, e_rdy, e_busy, e_starve};
    vecs.push_back(v);
  endtask

  // Apply one cycle of inputs after the falling edge and let them settle.
  task automatic drive(input logic rst, input logic wb_we, input logic [4:0] wb_a3,
                       input logic [31:0] wb_wd, input logic md_v, input logic [4:0] md_a3,
                       input logic [31:0] md_wd);
    @(negedge Clk);
    Reset       = rst;
    bus.WbWe    = wb_we;
    bus.WbA3    = wb_a3;
    bus.WbWd    = wb_wd;
    bus.MdValid = md_v;
    bus.MdA3    = md_a3;
    bus.MdWd    = md_wd;
    #1;
  endtask

  function automatic logic [31:0] bit_of(input int r);
    logic [31:0] one;
    one = 32'd1;
    return one << r;
  endfunction

  initial begin
    Reset       = 1'b1;
    bus.WbWe    = 1'b0;
    bus.WbA3    = '0;
    bus.WbWd    = '0;
    bus.MdValid = 1'b0;
    bus.MdA3    = '0;
    bus.MdWd    = '0;

    //   rst we a3 wd      mv a3 wd       | We A3 Wd      Rdy Busy                     Starve
    // reset held two cycles, then released
    add(1, 0, 0, 0,       0, 0, 0,        0, 0, 0,        0, 0,                        0);
    add(1, 0, 0, 0,       0, 0, 0,        0, 0, 0,        0, 0,                        0);
    add(0, 0, 0, 0,       0, 0, 0,        0, 0, 0,        1, 0,                        0);
    // single result, one-cycle drain
    add(0, 0, 0, 0,       1, 5, 'h1234,   0, 0, 0,        1, 0,                        0);
    add(0, 0, 0, 0,       0, 0, 0,        1, 5, 'h1234,   1, bit_of(5),                0);
    add(0, 0, 0, 0,       0, 0, 0,        0, 0, 0,        1, 0,                        0);
    // starvation: reg 9 buffered while WB writes reg 7 six cycles
    add(0, 0, 0, 0,       1, 9, 'h9999,   0, 0, 0,        1, 0,                        0);
    add(0, 1, 7, 'h77,    0, 0, 0,        1, 7, 'h77,     1, bit_of(9),                0);
    add(0, 1, 7, 'h77,    0, 0, 0,        1, 7, 'h77,     1, bit_of(9),                0);
    add(0, 1, 7, 'h77,    0, 0, 0,        1, 7, 'h77,     1, bit_of(9),                0);
    add(0, 1, 7, 'h77,    0, 0, 0,        1, 7, 'h77,     1, bit_of(9),                0);
    add(0, 1, 7, 'h77,    0, 0, 0,        1, 7, 'h77,     1, bit_of(9),                1);
    add(0, 1, 7, 'h77,    0, 0, 0,        1, 7, 'h77,     1, bit_of(9),                1);
    add(0, 0, 0, 0,       0, 0, 0,        1, 9, 'h9999,   1, bit_of(9),                1);
    add(0, 0, 0, 0,       0, 0, 0,        0, 0, 0,        1, 0,                        0);
    // fill to full, third result held off, in-order drain 3, 4, 5
    add(0, 1, 1, 'h11,    1, 3, 'h33,     1, 1, 'h11,     1, 0,                        0);
    add(0, 1, 1, 'h11,    1, 4, 'h44,     1, 1, 'h11,     1, bit_of(3),                0);
    add(0, 1, 1, 'h11,    1, 5, 'h55,     1, 1, 'h11,     0, bit_of(3) | bit_of(4),    0);
    add(0, 0, 0, 0,       1, 5, 'h55,     1, 3, 'h33,     0, bit_of(3) | bit_of(4),    0);
    add(0, 0, 0, 0,       1, 5, 'h55,     1, 4, 'h44,     1, bit_of(4),                0);
    add(0, 0, 0, 0,       0, 0, 0,        1, 5, 'h55,     1, bit_of(5),                0);
    add(0, 0, 0, 0,       0, 0, 0,        0, 0, 0,        1, 0,                        0);
    // WAW squash of a buffered reg 8 result
    add(0, 0, 0, 0,       1, 8, 'hBEEF,   0, 0, 0,        1, 0,                        0);
    add(0, 1, 8, 'hAAAA,  0, 0, 0,        1, 8, 'hAAAA,   1, bit_of(8),                0);
    add(0, 0, 0, 0,       0, 0, 0,        0, 0, 0,        1, 0,                        0);
    add(0, 0, 0, 0,       0, 0, 0,        0, 0, 0,        1, 0,                        0);
    // same-cycle push for the squashed register survives
    add(0, 1, 2, 'h22,    1, 6, 'h600,    1, 2, 'h22,     1, 0,                        0);
    add(0, 1, 6, 'h66,    1, 6, 'h601,    1, 6, 'h66,     1, bit_of(6),                0);
    add(0, 0, 0, 0,       0, 0, 0,        1, 6, 'h601,    1, bit_of(6),                0);
    add(0, 0, 0, 0,       0, 0, 0,        0, 0, 0,        1, 0,                        0);
    // register 0 on both sources is dropped
    add(0, 1, 0, 'hBEEF,  1, 0, 'hDEAD,   0, 0, 0,        1, 0,                        0);
    add(0, 0, 0, 0,       0, 0, 0,        0, 0, 0,        1, 0,                        0);
    // reset with a buffered result discards it
    add(0, 1, 1, 'h11,    1, 12, 'hC,     1, 1, 'h11,     1, 0,                        0);
    add(1, 0, 0, 0,       0, 0, 0,        0, 0, 0,        0, bit_of(12),               0);
    add(0, 0, 0, 0,       0, 0, 0,        0, 0, 0,        1, 0,                        0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].wb_we, vecs[i].wb_a3, vecs[i].wb_wd,
            vecs[i].md_v, vecs[i].md_a3, vecs[i].md_wd);
      check($sformatf("vec%0d.We", i),       bus.We,       vecs[i].e_we);
      check($sformatf("vec%0d.A3", i),       bus.A3,       vecs[i].e_a3);
      check($sformatf("vec%0d.Wd", i),       bus.Wd,       vecs[i].e_wd);
      check($sformatf("vec%0d.MdReady", i),  bus.MdReady,  vecs[i].e_rdy);
      check($sformatf("vec%0d.Busy", i),     bus.Busy,     vecs[i].e_busy);
      check($sformatf("vec%0d.MdStarve", i), bus.MdStarve, vecs[i].e_starve);
    end

    // Randomized traffic against the reference model (first cycle forces reset).
    mq.delete();
    m_age = 0;
    for (int c = 0; c < N_RAND; c++) begin
      logic        rst, wb_we, md_v, wb_act, rdy, popped, was_empty;
      logic [4:0]  wb_a3, md_a3;
      logic [31:0] wb_wd, md_wd, e_busy;
      logic        e_we;
      logic [4:0]  e_a3;
      logic [31:0] e_wd;
      ref_t        ent;

      rst   = (c == 0) || ($urandom_range(0, 99) < 2);
      wb_we = ($urandom_range(0, 99) < 55);
      wb_a3 = 5'($urandom_range(0, 7));
      wb_wd = $urandom;
      md_v  = ($urandom_range(0, 99) < 50);
      md_a3 = 5'($urandom_range(0, 7));
      md_wd = $urandom;
      drive(rst, wb_we, wb_a3, wb_wd, md_v, md_a3, md_wd);

      wb_act = !rst && wb_we && (wb_a3 != 5'd0);
      rdy    = !rst && (mq.size() < DEPTH);
      e_busy = '0;
      foreach (mq[j]) e_busy |= bit_of(int'(mq[j].a3));
      e_busy[0] = 1'b0;
      e_we = 1'b0;
      e_a3 = '0;
      e_wd = '0;
      if (wb_act) begin
        e_we = 1'b1; e_a3 = wb_a3; e_wd = wb_wd;
      end else if (!rst && mq.size() > 0) begin
        e_we = 1'b1; e_a3 = mq[0].a3; e_wd = mq[0].wd;
      end

      check($sformatf("rnd%0d.We", c),       bus.We,       e_we);
      check($sformatf("rnd%0d.A3", c),       bus.A3,       e_a3);
      check($sformatf("rnd%0d.Wd", c),       bus.Wd,       e_wd);
      check($sformatf("rnd%0d.MdReady", c),  bus.MdReady,  rdy);
      check($sformatf("rnd%0d.Busy", c),     bus.Busy,     e_busy);
      check($sformatf("rnd%0d.MdStarve", c), bus.MdStarve, m_age == STARVE_MAX);

      // Model update for the coming edge.
      if (rst) begin
        mq.delete();
        m_age = 0;
      end else begin
        was_empty = (mq.size() == 0);
        popped    = !wb_act && !was_empty;
        if (popped) void'(mq.pop_front());
        if (wb_act) begin
          for (int j = mq.size() - 1; j >= 0; j--) begin
            if (mq[j].a3 == wb_a3) mq.delete(j);
          end
        end
        if (md_v && rdy && (md_a3 != 5'd0)) begin
          ent.a3 = md_a3;
          ent.wd = md_wd;
          mq.push_back(ent);
        end
        if (popped || was_empty) m_age = 0;
        else if (m_age < STARVE_MAX) m_age++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
